// File: rtl/current_pi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : current_pi_ctrl
//  Purpose  : Three-stage pipelined PI current loop. Takes the unsigned motor
//             current target and the measured average current, and produces
//             a saturated 12-bit drive magnitude for the PWM stage. The
//             integrator advances once every 2^DECIM_W accepted samples and
//             is forced to zero, together with the drive, while the rider is
//             not pedaling.
//  Ports    : clk, rst_n        - clock, asynchronous active-low reset
//             vld               - one-cycle strobe qualifying the inputs
//             target_curr[11:0] - desired motor current (unsigned)
//             avg_curr[11:0]    - measured average motor current (unsigned)
//             not_pedaling      - level, clears integrator and drive
//             drv_mag[11:0]     - drive magnitude, held between updates
//             drv_vld           - one-cycle pulse when drv_mag updates
//  Revision : 1.0 - initial release
// ============================================================================
module current_pi_ctrl #(
  parameter int unsigned P_COEF  = 3,
  parameter int unsigned DECIM_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vld,
  input  logic [11:0] target_curr,
  input  logic [11:0] avg_curr,
  input  logic        not_pedaling,
  output logic [11:0] drv_mag,
  output logic        drv_vld
);

  localparam logic signed [13:0] C_P         = 14'(P_COEF);
  localparam logic        [16:0] C_INTEG_MAX = 17'h1FFFF;

  logic signed [12:0] err13;
  logic signed [10:0] err_sat;
  logic signed [10:0] err_d, err_q;
  logic signed [13:0] err_ext;
  logic signed [13:0] p_d, p_q;
  logic signed [18:0] integ_sum;
  logic        [16:0] integ_d, integ_q;
  logic               integ_fire;
  logic signed [14:0] sum;
  logic        [11:0] drv_mag_d, drv_mag_q;
  logic               s1_vld_q, s2_vld_q, drv_vld_q;

  // Decimation counter: integrator fires on the sample that finds the
  // counter at all-ones; with no counter bits it fires on every sample.
  generate
    if (DECIM_W > 0) begin : g_decim
      localparam logic [DECIM_W-1:0] C_CNT_ONE = DECIM_W'(1);
      logic [DECIM_W-1:0] cnt_d, cnt_q;

      always_comb begin
        cnt_d = cnt_q;
        if (not_pedaling) begin
          cnt_d = '0;
        end else if (s1_vld_q) begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign integ_fire = &cnt_q;
    end else begin : g_no_decim
      assign integ_fire = 1'b1;
    end
  endgenerate

  always_comb begin
    // Stage 1: 13-bit error saturated into 11-bit signed range.
    err13 = $signed({1'b0, target_curr}) - $signed({1'b0, avg_curr});
    if (err13 > 13'sd1023) begin
      err_sat = 11'sd1023;
    end else if (err13 < -13'sd1024) begin
      err_sat = -11'sd1024;
    end else begin
      err_sat = err13[10:0];
    end
    err_d = vld ? err_sat : err_q;

    // Stage 2: proportional term and integrator.
    err_ext   = {{3{err_q[10]}}, err_q};
    p_d       = s1_vld_q ? (err_ext * C_P) : p_q;
    integ_sum = $signed({2'b00, integ_q}) + $signed({{8{err_q[10]}}, err_q});

    integ_d = integ_q;
    if (not_pedaling) begin
      integ_d = '0;
    end else if (s1_vld_q && integ_fire) begin
      if (integ_sum[18]) begin
        integ_d = '0;
      end else if (integ_sum[17]) begin
        integ_d = C_INTEG_MAX;
      end else begin
        integ_d = integ_sum[16:0];
      end
    end

    // Stage 3: integ_q already holds this sample's integrator update.
    sum       = $signed({p_q[13], p_q}) + $signed({3'b000, integ_q[16:5]});
    drv_mag_d = drv_mag_q;
    if (s2_vld_q) begin
      if (not_pedaling || sum[14]) begin
        drv_mag_d = 12'h000;
      end else if (|sum[13:12]) begin
        drv_mag_d = 12'hFFF;
      end else begin
        drv_mag_d = sum[11:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= '0;
      s1_vld_q  <= 1'b0;
      p_q       <= '0;
      s2_vld_q  <= 1'b0;
      integ_q   <= '0;
      drv_mag_q <= '0;
      drv_vld_q <= 1'b0;
    end else begin
      err_q     <= err_d;
      s1_vld_q  <= vld;
      p_q       <= p_d;
      s2_vld_q  <= s1_vld_q;
      integ_q   <= integ_d;
      drv_mag_q <= drv_mag_d;
      drv_vld_q <= s2_vld_q;
    end
  end

  assign drv_mag = drv_mag_q;
  assign drv_vld = drv_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_current_pi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_current_pi_ctrl
//  Purpose  : Self-checking bench for current_pi_ctrl. Two instances run in
//             parallel (decimated and undecimated integrator) on a shared
//             stimulus plan; expected drive values come from a cycle-level
//             arithmetic model of the PI loop and are checked by a monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_current_pi_ctrl;

  localparam int MAXC = 1024;

  typedef struct {
    bit        v;
    bit [11:0] t;
    bit [11:0] a;
    bit        np;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld;
  logic [11:0] target_curr;
  logic [11:0] avg_curr;
  logic        not_pedaling;
  logic [11:0] drv_mag_a, drv_mag_b;
  logic        drv_vld_a, drv_vld_b;

  int    n_chk  = 0;
  int    n_pass = 0;
  stim_t plan[$];
  int    exp_tab[2][0:MAXC-1];
  int    q_a[$];
  int    q_b[$];
  int    last_a = 0;
  int    last_b = 0;

  current_pi_ctrl #(.P_COEF(3), .DECIM_W(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .vld(vld), .target_curr(target_curr),
    .avg_curr(avg_curr), .not_pedaling(not_pedaling),
    .drv_mag(drv_mag_a), .drv_vld(drv_vld_a)
  );

  current_pi_ctrl #(.P_COEF(2), .DECIM_W(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .vld(vld), .target_curr(target_curr),
    .avg_curr(avg_curr), .not_pedaling(not_pedaling),
    .drv_mag(drv_mag_b), .drv_vld(drv_vld_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  function automatic int sat_err(input int t, input int a);
    int d = t - a;
    if (d > 1023)  d = 1023;
    if (d < -1024) d = -1024;
    return d;
  endfunction

  task automatic add(input bit v, input int t, input int a, input bit np);
    stim_t s;
    s.v = v; s.t = 12'(t); s.a = 12'(a); s.np = np;
    plan.push_back(s);
  endtask

  // Reference: walk the plan clock by clock. A sample taken at cycle s
  // meets the integrator at the end of cycle s+1 and is converted to a
  // drive value at the end of cycle s+2 using the integrator as it stood
  // after its own update.
  task automatic run_model(input int sel, input int dw, input int pc);
    int integ  = 0;
    int cnt    = 0;
    int period = 1 << dw;
    for (int c = 0; c < plan.size(); c++) begin
      if (c >= 2 && plan[c-2].v) begin
        int s = sat_err(plan[c-2].t, plan[c-2].a) * pc + integ / 32;
        int e;
        if (plan[c].np || s < 0) e = 0;
        else if (s > 4095)       e = 4095;
        else                     e = s;
        exp_tab[sel][c-2] = e;
      end
      if (plan[c].np) begin
        integ = 0;
        cnt   = 0;
      end else if (c >= 1 && plan[c-1].v) begin
        bit fire = (cnt == period - 1);
        cnt = (cnt + 1) % period;
        if (fire) begin
          integ = integ + sat_err(plan[c-1].t, plan[c-1].a);
          if (integ < 0)      integ = 0;
          if (integ > 131071) integ = 131071;
        end
      end
    end
  endtask

  // Monitor: pops an expectation on every drv_vld, otherwise checks hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_a = 0;
      last_b = 0;
    end else begin
      if (drv_vld_a) begin
        if (q_a.size() == 0) check("unexpected drv_vld A", 1, 0);
        else                 check("drv_mag A", int'(drv_mag_a), q_a.pop_front());
        last_a = int'(drv_mag_a);
      end else begin
        check("hold drv_mag A", int'(drv_mag_a), last_a);
      end
      if (drv_vld_b) begin
        if (q_b.size() == 0) check("unexpected drv_vld B", 1, 0);
        else                 check("drv_mag B", int'(drv_mag_b), q_b.pop_front());
        last_b = int'(drv_mag_b);
      end else begin
        check("hold drv_mag B", int'(drv_mag_b), last_b);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst_n = 1'b0; vld = 1'b0; target_curr = '0; avg_curr = '0; not_pedaling = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset drv_mag A", int'(drv_mag_a), 0);
    check("reset drv_vld A", int'(drv_vld_a), 0);
    check("reset drv_mag B", int'(drv_mag_b), 0);
    check("reset drv_vld B", int'(drv_vld_b), 0);
    rst_n = 1'b1;

    // Basic error 256, spaced samples.
    for (int i = 0; i < 4; i++) begin
      add(1, 'h400, 'h300, 0);
      add(0, 0, 0, 0);
    end
    // Positive saturation, first sample after clear.
    add(0, 0, 0, 1);
    add(1, 'hFFF, 'h000, 0);
    add(0, 0, 0, 0); add(0, 0, 0, 0);
    // Negative floor.
    add(0, 0, 0, 1);
    add(1, 'h000, 'hFFF, 0);
    add(0, 0, 0, 0); add(0, 0, 0, 0);
    // Wind-up, back-to-back.
    add(0, 0, 0, 1);
    for (int i = 0; i < 140; i++) add(1, 'hFFF, 'h000, 0);
    // Not-pedaling over a sample in flight, then recovery.
    add(1, 'hFFF, 'h000, 1);
    add(0, 0, 0, 1); add(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) add(1, 'h400, 'h300, 0);
    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      int mode = $urandom_range(0, 3);
      int t    = $urandom_range(0, 4095);
      int a    = $urandom_range(0, 4095);
      if (mode == 2) a = t;
      if (mode == 3) begin
        t = ($urandom_range(0, 1) != 0) ? 'hFFF : 0;
        a = ($urandom_range(0, 1) != 0) ? 'hFFF : 0;
      end
      add($urandom_range(0, 9) < 6, t, a, $urandom_range(0, 99) < 4);
    end
    for (int i = 0; i < 3; i++) add(1, 'h400, 'h300, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0);

    if (plan.size() > MAXC) $fatal(1, "plan too long");
    run_model(0, 2, 3);
    run_model(1, 0, 2);

    for (int c = 0; c < plan.size(); c++) begin
      vld          = plan[c].v;
      target_curr  = plan[c].t;
      avg_curr     = plan[c].a;
      not_pedaling = plan[c].np;
      if (plan[c].v) begin
        q_a.push_back(exp_tab[0][c]);
        q_b.push_back(exp_tab[1][c]);
      end
      @(posedge clk);
      #1;
    end
    vld = 1'b0; not_pedaling = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard A drained", q_a.size(), 0);
    check("scoreboard B drained", q_b.size(), 0);

    // Reset one cycle after a sample: sample must vanish.
    vld = 1'b1; target_curr = 12'h400; avg_curr = 12'h300;
    @(posedge clk);
    #1;
    vld = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async reset drv_mag A", int'(drv_mag_a), 0);
    check("async reset drv_vld A", int'(drv_vld_a), 0);
    check("async reset drv_mag B", int'(drv_mag_b), 0);
    check("async reset drv_vld B", int'(drv_vld_b), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post-reset drv_mag A", int'(drv_mag_a), 0);
    check("post-reset drv_mag B", int'(drv_mag_b), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
